// File: rtl/sdc_buf_pkg.sv
// Shared definitions for the SD-read block buffer.
// Holds the default geometry of the buffer RAM and output stream, the
// number of output slices per RAM word, and the reader state encoding.
// No ports (package).
package sdc_buf_pkg;

  localparam int RAM_WIDTH_DEF     = 512;
  localparam int RAM_ADDR_BITS_DEF = 8;
  localparam int OUT_WIDTH_DEF     = 32;
  localparam int SLICES            = RAM_WIDTH_DEF / OUT_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of OUT_WIDTH slices in one RAM word.
  function automatic int slice_count(input int ram_w, input int out_w);
    return ram_w / out_w;
  endfunction

endpackage

// File: rtl/wide_word_serializer.sv
// Captures one wide RAM word and presents it LSB slice first on a
// valid/ready stream. Slice index and valid are held in registers so the
// stream outputs are stable while the sink stalls.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   load          capture word, restart at slice 0, raise valid
//   clear         drop valid immediately (cancel), wins over load/accept
//   word          wide input word
//   ready         sink ready
//   data          current slice
//   valid         slice valid
//   last_slice    current slice is the top slice of the word
//   accept        valid & ready handshake this cycle
module wide_word_serializer
  import sdc_buf_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [RAM_WIDTH-1:0] word,
  input  logic                 ready,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 valid,
  output logic                 last_slice,
  output logic                 accept
);

  localparam int SLICES_P = slice_count(RAM_WIDTH, OUT_WIDTH);
  localparam int IDX_BITS = (SLICES_P > 1) ? $clog2(SLICES_P) : 1;

  logic [RAM_WIDTH-1:0] shift_r;
  logic [IDX_BITS-1:0]  idx_r;
  logic                 valid_r;

  assign accept     = valid_r & ready;
  assign last_slice = (idx_r == IDX_BITS'(SLICES_P - 1));
  assign data       = shift_r[OUT_WIDTH-1:0];
  assign valid      = valid_r;

  // Shift register, slice index and valid flag; the word shifts right so the
  // presented slice is always the low OUT_WIDTH bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= {RAM_WIDTH{1'b0}};
      idx_r   <= {IDX_BITS{1'b0}};
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= word;
      idx_r   <= {IDX_BITS{1'b0}};
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      if (last_slice) begin
        valid_r <= 1'b0;
      end else begin
        shift_r <= shift_r >> OUT_WIDTH;
        idx_r   <= idx_r + IDX_BITS'(1);
      end
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/sdc_ram_block_reader.sv
// Read side of the SD-read block buffer. Drains a run of RAM words starting
// at base_addr and streams each as LSB-first OUT_WIDTH slices.
// Ports:
//   clk, reset_n          clock / async active-low reset
//   start, base_addr,     transfer request (sampled only when idle);
//   word_cnt              word_cnt==0 just pulses done
//   abort                 cancel current transfer (no done)
//   ram_addr / ram_data   async-read RAM port, owned while busy
//   out_data, out_valid,  slice stream; out_last marks final slice of
//   out_ready, out_last   final word
//   busy, done            status: busy while not idle, done 1-cycle pulse
module sdc_ram_block_reader
  import sdc_buf_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int OUT_WIDTH     = OUT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   word_cnt,
  input  logic                     abort,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = RAM_ADDR_BITS + 1;

  state_e                   state_r;
  state_e                   state_s;
  logic [RAM_ADDR_BITS-1:0] addr_r;
  logic [CW-1:0]            words_left_r;
  logic                     busy_r;
  logic                     done_r;

  logic start_xfer_s;
  logic next_word_s;
  logic load_s;
  logic clear_s;
  logic ser_accept_s;
  logic ser_last_s;
  logic ser_valid_s;

  wide_word_serializer #(
    .RAM_WIDTH (RAM_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .clear      (clear_s),
    .word       (ram_data),
    .ready      (out_ready),
    .data       (out_data),
    .valid      (ser_valid_s),
    .last_slice (ser_last_s),
    .accept     (ser_accept_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and control strobes. Abort is checked before the handshake so
  // a beat accepted in the same cycle still ends the transfer.
  always_comb begin
    state_s      = state_r;
    start_xfer_s = 1'b0;
    next_word_s  = 1'b0;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt != {CW{1'b0}}) begin
            start_xfer_s = 1'b1;
            state_s      = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          clear_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          load_s  = 1'b1;
          state_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          clear_s = 1'b1;
          state_s = ST_IDLE;
        end else if (ser_accept_s && ser_last_s) begin
          if (words_left_r > CW'(1)) begin
            next_word_s = 1'b1;
            state_s     = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // RAM address and remaining-word counter; the address wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r       <= {RAM_ADDR_BITS{1'b0}};
      words_left_r <= {CW{1'b0}};
    end else if (start_xfer_s) begin
      addr_r       <= base_addr;
      words_left_r <= word_cnt;
    end else if (next_word_s) begin
      addr_r       <= addr_r + RAM_ADDR_BITS'(1);
      words_left_r <= words_left_r - CW'(1);
    end else begin
      addr_r       <= addr_r;
      words_left_r <= words_left_r;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign ram_addr  = addr_r;
  assign out_valid = ser_valid_s;
  assign out_last  = (words_left_r == CW'(1)) & ser_last_s & ser_valid_s;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
